pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Program-counter stage of the pipelined MIPS core.
- Sits directly downstream of the branch-offset left-shift stage and consumes its 32-bit shifted offset.
- Holds the fetch PC and the IF/ID PC pipeline register, and computes branch, jump and jr targets.
- Arbitrates redirects against pipeline stalls and drives the IF-stage squash.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
PC_STEP, 4, sequential increment in bytes

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_if  input  1  hazard unit: hold PC and IF/ID register
branch_taken  input  1  ID-stage branch resolved taken
branch_offset_sl2  input  32  sign-extended offset already shifted left by 2
jump  input  1  ID-stage j/jal
jump_index  input  26  instr[25:0]
jr  input  1  ID-stage jr/jalr
jr_target  input  32  register-file rs value
pc_if  output  32  current fetch address
pc_plus4_if  output  32  pc_if + PC_STEP (combinational)
pc_id  output  32  PC of instruction in ID
pc_plus4_id  output  32  pc_id + PC_STEP, registered
id_valid  output  1  ID instruction is not a bubble
flush_if  output  1  squash instruction currently being fetched
redirect_pending  output  1  FSM in PENDING
addr_err  output  1  one-cycle pulse: jr target misaligned

Behaviour:
- Reset (async, rst_n=0): pc_if=RESET_PC; pc_id=0; pc_plus4_id=0; id_valid=0; flush_if=0; addr_err=0; FSM=IDLE; pending target=0.
- Target arithmetic, all modulo 2^32, no overflow detection:
  - branch target = pc_plus4_id + branch_offset_sl2
  - jump target = {pc_plus4_id[31:28], jump_index, 2'b00}
  - jr target = {jr_target[31:2], 2'b00}
- Redirect priority when several are asserted: jr > jump > branch_taken > sequential. Redirect inputs are qualified by id_valid; they are ignored when id_valid=0.
- Sequential wrap: pc_if=32'hFFFF_FFFC advances to 32'h0000_0000.
- FSM IDLE:
  - no stall, no redirect: pc_if <= pc_plus4_if; pc_id <= pc_if; pc_plus4_id <= pc_plus4_if; id_valid <= 1.
  - no stall, redirect: pc_if <= target; pc_id/pc_plus4_id load as above; id_valid <= 0. flush_if=1 combinationally in this cycle.
  - stall and redirect: latch target into the pending register and go to PENDING. pc_if, pc_id and id_valid hold. flush_if=0.
  - stall, no redirect: all registers hold.
- FSM PENDING:
  - redirect inputs are ignored; the first redirect wins.
  - while stall_if=1: hold.
  - first cycle with stall_if=0: pc_if <= pending target; id_valid <= 0; flush_if=1; return to IDLE.
- Redirect latency: the target appears on pc_if one clock after the committing cycle.
- addr_err pulses for one cycle when a jr is accepted (in IDLE, qualified) and jr_target[1:0] != 0. It is registered and asserts the cycle after acceptance. The redirect still proceeds to the aligned address.
- Reset asserted mid-PENDING discards the pending target.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - flush_if is tied 0.
  - On commit, id_valid <= 1, so the slot instruction executes.
  - When a redirect arrives during stall, the redirect still goes to PENDING.
- Undefined: the flush behaviour above (squash the fetched instruction).

Test Plan:
- Reset to RESET_PC=0, no stall, 3 clocks -> pc_if 0,4,8,C; pc_id trails pc_if by one cycle; id_valid=1 from the second cycle.
- pc_id=0x100 (pc_plus4_id=0x104), branch_taken=1, offset=0xFFFF_FFF0 -> next pc_if=0x0000_00F4; flush_if=1 in the branch cycle; id_valid=0 next cycle.
- jump=1, jr=1 and branch_taken=1 together, jr_target=0x0000_2003 -> pc_if=0x0000_2000; addr_err pulses one cycle.
- stall_if=1 with jump_index=0x000_0040, pc_plus4_id=0x1000_0010 -> redirect_pending=1 and pc_if holds for 2 stall cycles; then pc_if=0x1000_0100 and flush_if=1 in the release cycle.
- pc_if=0xFFFF_FFFC, no redirect -> pc_if=0x0000_0000; rst_n pulsed low during PENDING -> pc_if=RESET_PC immediately and redirect_pending=0.
- With BRANCH_DELAY_SLOT_EN defined, repeat the branch test -> flush_if stays 0 and id_valid=1 after the redirect.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter stage: fetch PC, IF/ID PC register, branch/jump/jr target
// selection and redirect-vs-stall arbitration. Define BRANCH_DELAY_SLOT_EN for
// MIPS delay-slot semantics (no IF squash; the slot instruction stays valid).
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset_sl2,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus4_if,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic        id_valid,
  output logic        flush_if,
  output logic        redirect_pending,
  output logic        addr_err
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic SQUASH = 1'b0;
`else
  localparam logic SQUASH = 1'b1;
`endif

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state, state_n;
  logic [31:0] pending_target, pending_target_n;
  logic [31:0] pc_if_n, pc_id_n, pc_plus4_id_n;
  logic        id_valid_n, addr_err_n;

  logic        jr_q, jump_q, branch_q, redirect;
  logic [31:0] target;

  // Redirect requests from a bubble in ID are meaningless and must be ignored.
  assign jr_q     = id_valid & jr;
  assign jump_q   = id_valid & jump;
  assign branch_q = id_valid & branch_taken;
  assign redirect = jr_q | jump_q | branch_q;

  assign pc_plus4_if      = pc_if + STEP;
  assign redirect_pending = (state == PENDING);

  always_comb begin
    if (jr_q)
      target = {jr_target[31:2], 2'b00};
    else if (jump_q)
      target = {pc_plus4_id[31:28], jump_index, 2'b00};
    else
      target = pc_plus4_id + branch_offset_sl2;
  end

  // NOTE: every combinational output gets a hold/default value first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_n          = state;
    pending_target_n = pending_target;
    pc_if_n          = pc_if;
    pc_id_n          = pc_id;
    pc_plus4_id_n    = pc_plus4_id;
    id_valid_n       = id_valid;
    flush_if         = 1'b0;
    addr_err_n       = 1'b0;

    case (state)
      IDLE: begin
        addr_err_n = jr_q & (jr_target[1:0] != 2'b00);
        if (!stall_if) begin
          pc_id_n       = pc_if;
          pc_plus4_id_n = pc_plus4_if;
          if (redirect) begin
            pc_if_n    = target;
            id_valid_n = ~SQUASH;
            flush_if   = SQUASH;
          end else begin
            pc_if_n    = pc_plus4_if;
            id_valid_n = 1'b1;
          end
        end else if (redirect) begin
          pending_target_n = target;
          state_n          = PENDING;
        end
      end

      PENDING: begin
        // The first redirect already won; new requests are not looked at here.
        if (!stall_if) begin
          pc_if_n       = pending_target;
          pc_id_n       = pc_if;
          pc_plus4_id_n = pc_plus4_if;
          id_valid_n    = ~SQUASH;
          flush_if      = SQUASH;
          state_n       = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pending_target <= '0;
      pc_if          <= RESET_PC;
      pc_id          <= '0;
      pc_plus4_id    <= '0;
      id_valid       <= 1'b0;
      addr_err       <= 1'b0;
    end else begin
      state          <= state_n;
      pending_target <= pending_target_n;
      pc_if          <= pc_if_n;
      pc_id          <= pc_id_n;
      pc_plus4_id    <= pc_plus4_id_n;
      id_valid       <= id_valid_n;
      addr_err       <= addr_err_n;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: reset, sequential fetch, branch/jump/jr
// redirects, priority, stall-pending release, wrap and reset during PENDING.
module tb_pc_next_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic [31:0] FLUSH_ON    = 32'd0;
  localparam logic [31:0] VALID_AFTER = 32'd1;
`else
  localparam logic [31:0] FLUSH_ON    = 32'd1;
  localparam logic [31:0] VALID_AFTER = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if;
  logic        branch_taken;
  logic [31:0] branch_offset_sl2;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc_if, pc_plus4_if, pc_id, pc_plus4_id;
  logic        id_valid, flush_if, redirect_pending, addr_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_next_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_if          (stall_if),
    .branch_taken      (branch_taken),
    .branch_offset_sl2 (branch_offset_sl2),
    .jump              (jump),
    .jump_index        (jump_index),
    .jr                (jr),
    .jr_target         (jr_target),
    .pc_if             (pc_if),
    .pc_plus4_if       (pc_plus4_if),
    .pc_id             (pc_id),
    .pc_plus4_id       (pc_plus4_id),
    .id_valid          (id_valid),
    .flush_if          (flush_if),
    .redirect_pending  (redirect_pending),
    .addr_err          (addr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch_taken = 1'b0;
    jump         = 1'b0;
    jr           = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall_if = 1'b0; branch_taken = 1'b0; branch_offset_sl2 = '0;
    jump = 1'b0; jump_index = '0; jr = 1'b0; jr_target = '0;

    #12;
    check("rst_pc_if", pc_if, 32'h0);
    check("rst_pc_plus4_if", pc_plus4_if, 32'h4);
    check("rst_pc_id", pc_id, 32'h0);
    check("rst_pc_plus4_id", pc_plus4_id, 32'h0);
    check("rst_id_valid", id_valid, 32'd0);
    check("rst_flush_if", flush_if, 32'd0);
    check("rst_addr_err", addr_err, 32'd0);
    check("rst_pending", redirect_pending, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch
    step();
    check("seq1_pc_if", pc_if, 32'h4);
    check("seq1_pc_id", pc_id, 32'h0);
    check("seq1_id_valid", id_valid, 32'd1);
    step();
    check("seq2_pc_if", pc_if, 32'h8);
    check("seq2_pc_id", pc_id, 32'h4);
    step();
    check("seq3_pc_if", pc_if, 32'hC);
    check("seq3_pc_id", pc_id, 32'h8);
    check("seq3_pc_plus4_if", pc_plus4_if, 32'h10);

    // Jump to 0x100 to set up the branch test
    jump = 1'b1; jump_index = 26'h40;
    #1 check("jmp_flush", flush_if, FLUSH_ON);
    step();
    clear_redirects();
    check("jmp_pc_if", pc_if, 32'h100);
    check("jmp_id_valid", id_valid, VALID_AFTER);
    branch_taken = 1'b1; branch_offset_sl2 = 32'hFFFF_FFF0;
    #1 check("bubble_branch_ignored", flush_if, 32'd0);
    clear_redirects();
    step();
    check("pre_br_pc_id", pc_id, 32'h100);
    check("pre_br_pc_plus4_id", pc_plus4_id, 32'h104);
    check("pre_br_id_valid", id_valid, 32'd1);

    // Backward branch: 0x104 + 0xFFFF_FFF0
    branch_taken = 1'b1; branch_offset_sl2 = 32'hFFFF_FFF0;
    #1 check("br_flush", flush_if, FLUSH_ON);
    step();
    clear_redirects();
    check("br_pc_if", pc_if, 32'h0000_00F4);
    check("br_id_valid", id_valid, VALID_AFTER);
    step();
    check("post_br_pc_if", pc_if, 32'hF8);
    check("post_br_id_valid", id_valid, 32'd1);

    // All three redirects at once: jr wins, misaligned target
    jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
    jr_target = 32'h0000_2003; jump_index = 26'h40; branch_offset_sl2 = 32'hFFFF_FFF0;
    #1 check("prio_flush", flush_if, FLUSH_ON);
    check("prio_addr_err_pre", addr_err, 32'd0);
    step();
    clear_redirects();
    check("prio_pc_if", pc_if, 32'h0000_2000);
    check("prio_addr_err", addr_err, 32'd1);
    step();
    check("prio_addr_err_drop", addr_err, 32'd0);
    check("prio_next_pc_if", pc_if, 32'h2004);
    check("prio_pc_id", pc_id, 32'h2000);

    // Aligned jr to set pc_plus4_id = 0x1000_0010
    jr = 1'b1; jr_target = 32'h1000_000C;
    step();
    clear_redirects();
    check("jr_al_pc_if", pc_if, 32'h1000_000C);
    check("jr_al_addr_err", addr_err, 32'd0);
    step();
    check("stall_setup_pc_plus4_id", pc_plus4_id, 32'h1000_0010);

    // Jump under stall goes PENDING; later redirects are ignored
    stall_if = 1'b1; jump = 1'b1; jump_index = 26'h40;
    #1 check("stall_flush", flush_if, 32'd0);
    step();
    check("pend1", redirect_pending, 32'd1);
    check("pend1_pc_if", pc_if, 32'h1000_0010);
    check("pend1_pc_id", pc_id, 32'h1000_000C);
    check("pend1_id_valid", id_valid, 32'd1);
    jump = 1'b0; branch_taken = 1'b1; branch_offset_sl2 = 32'h40;
    step();
    check("pend2", redirect_pending, 32'd1);
    check("pend2_pc_if", pc_if, 32'h1000_0010);
    stall_if = 1'b0;
    #1 check("release_flush", flush_if, FLUSH_ON);
    check("release_pending", redirect_pending, 32'd1);
    step();
    clear_redirects();
    check("release_pc_if", pc_if, 32'h1000_0100);
    check("release_pend_clr", redirect_pending, 32'd0);
    check("release_id_valid", id_valid, VALID_AFTER);
    step();
    check("post_rel_pc_if", pc_if, 32'h1000_0104);

    // Wrap at the top of the address space
    jr = 1'b1; jr_target = 32'hFFFF_FFFC;
    step();
    clear_redirects();
    check("wrap_pc_if", pc_if, 32'hFFFF_FFFC);
    check("wrap_pc_plus4_if", pc_plus4_if, 32'h0);
    step();
    check("wrap_next_pc_if", pc_if, 32'h0);
    check("wrap_pc_plus4_id", pc_plus4_id, 32'h0);
    step();
    check("wrap2_pc_if", pc_if, 32'h4);

    // Reset during PENDING discards the pending target
    stall_if = 1'b1; jump = 1'b1; jump_index = 26'h123;
    step();
    check("rp_pending", redirect_pending, 32'd1);
    check("rp_pc_if_hold", pc_if, 32'h4);
    #2 rst_n = 1'b0;
    #1 check("rp_pc_if", pc_if, 32'h0);
    check("rp_pending_clr", redirect_pending, 32'd0);
    check("rp_id_valid", id_valid, 32'd0);
    stall_if = 1'b0;
    clear_redirects();
    rst_n = 1'b1;
    step();
    check("rp_after_pc_if", pc_if, 32'h4);
    check("rp_after_pending", redirect_pending, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
